test_mux_scan_ctrl: RTL

//  Auto-scan sequencer for the test-signal multiplexer bank. Holds a small table of per-mux channel

---
 rtl/test_mux_scan_ctrl_pkg.sv | 6 +
 rtl/test_mux_scan_tab.sv | 23 ++
 rtl/test_mux_scan_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/test_mux_scan_ctrl_pkg.sv
// test_mux_pkg: shared constants and FSM state type for the test-mux scan sequencer
package test_mux_pkg;
  localparam int CSelW = 6;
  localparam int CTabLenDef = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DWELL} tScanState;
endpackage

// File: rtl/test_mux_scan_tab.sv
// test_mux_scan_tab: scan table register file, one write port, one combinational read port
module test_mux_scan_tab
  import test_mux_pkg::*;
#(
  parameter int CMuxCnt = 2,
  parameter int CTabLen = CTabLenDef,
  parameter int CTabAw = $clog2(CTabLen)
) (
  input  logic                       AClkH,
  input  logic                       AResetH,
  input  logic                       AClkHEn,
  input  logic                       AWrEn,
  input  logic [CTabAw-1:0]          AWrAddr,
  input  logic [CMuxCnt*CSelW-1:0]   AWrData,
  input  logic [CTabAw-1:0]          ARdAddr,
  output logic [CMuxCnt*CSelW-1:0]   ARdData
);
  logic [CMuxCnt*CSelW-1:0] mem [CTabLen];
  always_ff @(posedge AClkH or posedge AResetH)
    if (AResetH) for (int i = 0; i < CTabLen; i++) mem[i] <= '0;
    else if (AClkHEn && AWrEn) mem[AWrAddr] <= AWrData;
  assign ARdData = mem[ARdAddr];
endmodule

// File: rtl/test_mux_scan_ctrl.sv
// test_mux_scan_ctrl: steps a select table into the test muxes with settle and sample windows
module test_mux_scan_ctrl
  import test_mux_pkg::*;
#(
  parameter int CMuxCnt = 2,
  parameter int CTabLen = CTabLenDef,
  parameter int CTabAw = $clog2(CTabLen)
) (
  input  logic                       AClkH,
  input  logic                       AResetH,
  input  logic                       AClkHEn,
  input  logic                       ATabWrEn,
  input  logic [CTabAw-1:0]          ATabWrAddr,
  input  logic [CMuxCnt*CSelW-1:0]   ATabWrData,
  input  logic                       AStart,
  input  logic                       AStop,
  input  logic                       AOneShot,
  input  logic [CTabAw-1:0]          ALastIdx,
  input  logic [3:0]                 ASettle,
  input  logic [15:0]                ADwell,
  output logic [CMuxCnt*CSelW-1:0]   ASelIdx,
  output logic [CMuxCnt-1:0]         ASelWrEn,
  output logic                       ASampleEn,
  output logic [CTabAw-1:0]          AStepIdx,
  output logic                       ABusy,
  output logic                       ADone
);
  tScanState state, nextState;
  logic [15:0] cnt, dwell;
  logic [3:0] settle;
  logic [CTabAw-1:0] step, lastIdx;
  logic oneShot, settleEnd, dwellEnd, lastStep;
  logic [CMuxCnt*CSelW-1:0] rowData;
  test_mux_scan_tab #(.CMuxCnt(CMuxCnt), .CTabLen(CTabLen), .CTabAw(CTabAw)) uTab (
    .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn),
    .AWrEn(ATabWrEn), .AWrAddr(ATabWrAddr), .AWrData(ATabWrData),
    .ARdAddr(step), .ARdData(rowData)
  );
  assign settleEnd = state == SETTLE && cnt == {12'd0, settle} - 16'd1;
  assign dwellEnd = state == DWELL && cnt == dwell;
  assign lastStep = step == lastIdx;
  // one counter serves both waits; it restarts on every state change
  always_ff @(posedge AClkH or posedge AResetH)
    if (AResetH) begin
      state <= IDLE;
      cnt <= '0;
      step <= '0;
      oneShot <= 1'b0;
      lastIdx <= '0;
      settle <= '0;
      dwell <= '0;
    end else if (AClkHEn) begin
      state <= nextState;
      cnt <= (nextState != state || state == IDLE) ? '0 : cnt + 16'd1;
      if (state == IDLE && nextState == LOAD) begin
        oneShot <= AOneShot;
        lastIdx <= ALastIdx;
        settle <= ASettle;
        dwell <= ADwell;
        step <= '0;
      end else if (nextState == IDLE) step <= '0;
      else if (dwellEnd) step <= lastStep ? '0 : step + CTabAw'(1);
    end
  always_comb begin
    nextState = state;
    if (AStop) nextState = IDLE;
    else if (state == IDLE && AStart) nextState = LOAD;
    else if (state == LOAD) nextState = settle != 4'd0 ? SETTLE : DWELL;
    else if (settleEnd) nextState = DWELL;
    else if (dwellEnd) nextState = (lastStep && oneShot) ? IDLE : LOAD;
  end
  always_comb begin
    ASelWrEn = (state == LOAD && !AStop) ? '1 : '0;
    ASelIdx = state == LOAD ? rowData : '0;
    ASampleEn = state == DWELL;
    AStepIdx = step;
    ABusy = state != IDLE;
    ADone = dwellEnd && lastStep && oneShot && !AStop;
  end
endmodule
